// File: rtl/mem_copy_initiator.sv
// Block-copy engine that takes over the data-memory port.
// For each word it spends one cycle reading and one cycle writing, and the
// pointers move up by one word each time.
// Strobes and addresses are registered from the next-state decision. This
// keeps them Moore with respect to the state, and the asynchronous reset
// forces them low at once.
module mem_copy_initiator #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int COUNT_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  src_addr,
    input  logic [ADDR_WIDTH-1:0]  dst_addr,
    input  logic [COUNT_WIDTH-1:0] word_count,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_WIDTH-1:0]  mem_address,
    output logic [DATA_WIDTH-1:0]  mem_write_data,
    output logic                   mem_write,
    output logic                   mem_read,
    input  logic [DATA_WIDTH-1:0]  mem_read_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  src_ptr;
    logic [ADDR_WIDTH-1:0]  dst_ptr;
    logic [COUNT_WIDTH-1:0] remaining;
    logic [DATA_WIDTH-1:0]  data_reg;

    // The captured word is driven only while the write strobe is high.
    // At every other time the data bus reads zero.
    assign mem_write_data = mem_write ? data_reg : '0;

    // Copy sequencer: state, pointers, captured data and registered strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            src_ptr     <= '0;
            dst_ptr     <= '0;
            remaining   <= '0;
            data_reg    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
        end else begin
            // Each branch below raises only the outputs for the state it enters.
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr   <= src_addr;
                        dst_ptr   <= dst_addr;
                        remaining <= word_count;
                        if (word_count != '0) begin
                            state       <= READ;
                            busy        <= 1'b1;
                            mem_read    <= 1'b1;
                            mem_address <= src_addr;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    // The memory read is combinational, so the word is valid now.
                    data_reg    <= mem_read_data;
                    state       <= WRITE;
                    busy        <= 1'b1;
                    mem_write   <= 1'b1;
                    mem_address <= dst_ptr;
                end
                WRITE: begin
                    src_ptr   <= src_ptr + ADDR_WIDTH'(1);
                    dst_ptr   <= dst_ptr + ADDR_WIDTH'(1);
                    remaining <= remaining - COUNT_WIDTH'(1);
                    if (remaining == COUNT_WIDTH'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state       <= READ;
                        busy        <= 1'b1;
                        mem_read    <= 1'b1;
                        mem_address <= src_ptr + ADDR_WIDTH'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_initiator.sv
// Directed bench for mem_copy_initiator. It uses a small word-indexed memory
// model with a combinational read, indexed by the low 8 address bits.
module tb_mem_copy_initiator;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [9:0]  word_count;
    logic        busy;
    logic        done;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:255];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_copy_initiator #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .COUNT_WIDTH(10)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .src_addr(src_addr),
        .dst_addr(dst_addr),
        .word_count(word_count),
        .busy(busy),
        .done(done),
        .mem_address(mem_address),
        .mem_write_data(mem_write_data),
        .mem_write(mem_write),
        .mem_read(mem_read),
        .mem_read_data(mem_read_data)
    );

    // Memory model: combinational read; preload port or DUT write on the clock.
    assign mem_read_data = mem[mem_address[7:0]];
    always @(posedge clk) begin
        if (pl_en)
            mem[pl_addr] <= pl_data;
        else if (mem_write)
            mem[mem_address[7:0]] <= mem_write_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        step();
        pl_en = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".busy"}, busy, 1'b0);
        chk({tag, ".mrd"},  mem_read, 1'b0);
        chk({tag, ".mwr"},  mem_write, 1'b0);
        chk({tag, ".addr"}, mem_address, 32'h0);
        chk({tag, ".wdat"}, mem_write_data, 32'h0);
    endtask

    // Waits at most max_cycles cycles for done. Running out of cycles counts as a failure.
    task automatic wait_done(input int max_cycles, input string tag);
        int n;
        n = 0;
        while (!done && n < max_cycles) begin
            step();
            n++;
        end
        chk({tag, ".done_seen"}, done, 1'b1);
    endtask

    initial begin
        logic [31:0] exp_addr [0:7];
        logic [31:0] exp_wdat [0:7];
        int dn;
        int dcyc;
        exp_addr = '{32'd10, 32'd100, 32'd11, 32'd101, 32'd12, 32'd102, 32'd13, 32'd103};
        exp_wdat = '{32'h0, 32'hA, 32'h0, 32'hB, 32'h0, 32'hC, 32'h0, 32'hD};

        reset = 1'b0; start = 1'b1; src_addr = '0; dst_addr = '0; word_count = '0;

        // Hold reset with start high; everything stays low.
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle_outputs("rst");
            chk("rst.done", done, 1'b0);
        end
        // Release reset. The first start edge, with count 0, is accepted.
        reset = 1'b1;
        step();
        chk("rst_rel.done", done, 1'b1);
        start = 1'b0;
        step();
        chk("rst_rel.done_gone", done, 1'b0);

        // Basic copy of four words.
        preload(8'd10, 32'hA); preload(8'd11, 32'hB);
        preload(8'd12, 32'hC); preload(8'd13, 32'hD);
        preload(8'd104, 32'h5A5A);
        src_addr = 32'd10; dst_addr = 32'd100; word_count = 10'd4; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("basic.c%0d.busy", i + 1), busy, 1'b1);
            chk($sformatf("basic.c%0d.mrd", i + 1), mem_read, (i % 2 == 0));
            chk($sformatf("basic.c%0d.mwr", i + 1), mem_write, (i % 2 == 1));
            chk($sformatf("basic.c%0d.addr", i + 1), mem_address, exp_addr[i]);
            chk($sformatf("basic.c%0d.wdat", i + 1), mem_write_data, exp_wdat[i]);
            chk($sformatf("basic.c%0d.done", i + 1), done, 1'b0);
            step();
        end
        chk("basic.c9.done", done, 1'b1);
        chk("basic.c9.busy", busy, 1'b0);
        step();
        chk("basic.c10.done", done, 1'b0);
        chk("basic.mem100", mem[100], 32'hA);
        chk("basic.mem101", mem[101], 32'hB);
        chk("basic.mem102", mem[102], 32'hC);
        chk("basic.mem103", mem[103], 32'hD);
        chk("basic.mem104", mem[104], 32'h5A5A);

        // Zero count: done in cycle 1 with no memory access.
        word_count = 10'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("zero.done", done, 1'b1);
        chk_idle_outputs("zero");
        step();
        chk("zero.done_gone", done, 1'b0);

        // Start pulses and input changes during an active copy are ignored.
        preload(8'd30, 32'h11); preload(8'd31, 32'h22); preload(8'd32, 32'h33);
        src_addr = 32'd30; dst_addr = 32'd60; word_count = 10'd3; start = 1'b1;
        step();                      // cycle 1
        start = 1'b0;
        step();                      // cycle 2
        step();                      // cycle 3
        start = 1'b1; src_addr = 32'd200; dst_addr = 32'd201; word_count = 10'd1;
        step();                      // cycle 4
        start = 1'b0;
        chk("ign.c4.addr", mem_address, 32'd61);
        dn = 0; dcyc = 0;
        for (int c = 4; c < 14; c++) begin
            if (done) begin
                dn++;
                dcyc = c;
            end
            step();
        end
        chk("ign.done_count", dn, 1);
        chk("ign.done_cycle", dcyc, 7);
        chk("ign.mem60", mem[60], 32'h11);
        chk("ign.mem61", mem[61], 32'h22);
        chk("ign.mem62", mem[62], 32'h33);

        // The source pointer wraps from the top address to 0.
        preload(8'd255, 32'h55); preload(8'd0, 32'h66);
        src_addr = 32'hFFFF_FFFF; dst_addr = 32'd50; word_count = 10'd2; start = 1'b1;
        step();
        start = 1'b0;
        chk("wrap.c1.addr", mem_address, 32'hFFFF_FFFF);
        chk("wrap.c1.mrd", mem_read, 1'b1);
        step(); step();
        chk("wrap.c3.addr", mem_address, 32'h0);
        chk("wrap.c3.mrd", mem_read, 1'b1);
        wait_done(6, "wrap");
        step();
        chk("wrap.mem50", mem[50], 32'h55);
        chk("wrap.mem51", mem[51], 32'h66);

        // Reset during the second WRITE aborts the copy asynchronously.
        preload(8'd150, 32'hDEAD); preload(8'd151, 32'hDEAD);
        preload(8'd152, 32'hDEAD); preload(8'd153, 32'hDEAD);
        src_addr = 32'd10; dst_addr = 32'd150; word_count = 10'd4; start = 1'b1;
        step();                      // cycle 1
        start = 1'b0;
        step(); step(); step();      // cycle 4, second WRITE
        chk("rmid.c4.mwr", mem_write, 1'b1);
        chk("rmid.c4.addr", mem_address, 32'd151);
        #3;
        reset = 1'b0;
        #1;
        chk_idle_outputs("rmid.async");
        chk("rmid.async.done", done, 1'b0);
        @(posedge clk); #1;
        chk("rmid.held.done", done, 1'b0);
        reset = 1'b1;
        step();
        chk("rmid.after.done", done, 1'b0);
        chk("rmid.after.busy", busy, 1'b0);
        chk("rmid.mem150", mem[150], 32'hA);
        chk("rmid.mem151", mem[151], 32'hDEAD);
        chk("rmid.mem152", mem[152], 32'hDEAD);
        chk("rmid.mem153", mem[153], 32'hDEAD);
        src_addr = 32'd11; dst_addr = 32'd151; word_count = 10'd1; start = 1'b1;
        step();                      // cycle 1
        start = 1'b0;
        chk("rre.c1.addr", mem_address, 32'd11);
        step();                      // cycle 2
        chk("rre.c2.wdat", mem_write_data, 32'hB);
        step();                      // cycle 3
        chk("rre.c3.done", done, 1'b1);
        step();
        chk("rre.mem151", mem[151], 32'hB);

        // Overlapping copy, with start held high to launch back-to-back copies.
        preload(8'd20, 32'd1); preload(8'd21, 32'd2); preload(8'd22, 32'd3);
        src_addr = 32'd20; dst_addr = 32'd21; word_count = 10'd2; start = 1'b1;
        step();                      // cycle 1
        chk("ovl.c1.addr", mem_address, 32'd20);
        step(); step(); step(); step(); // cycle 5
        chk("ovl.c5.done", done, 1'b1);
        chk("ovl.mem21", mem[21], 32'd1);
        chk("ovl.mem22", mem[22], 32'd1);
        step();                      // cycle 6, IDLE
        chk("ovl.c6.busy", busy, 1'b0);
        chk("ovl.c6.done", done, 1'b0);
        step();                      // cycle 7, second copy starts
        chk("ovl.c7.busy", busy, 1'b1);
        chk("ovl.c7.mrd", mem_read, 1'b1);
        chk("ovl.c7.addr", mem_address, 32'd20);
        start = 1'b0;
        wait_done(8, "ovl2");
        step();
        chk("ovl2.idle.busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
